// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - digit data, control and pin signals of the 7-segment scan driver
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    update;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   ans;
    logic                    frame_start;

    modport master (
        output digits_in, dp_in, blank_in, brightness, update,
        input  seg, dp, ans, frame_start
    );

    modport slave (
        input  digits_in, dp_in, blank_in, brightness, update,
        output seg, dp, ans, frame_start
    );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed 7-segment driver with PWM, guard band and double buffer; option LEADING_ZERO_BLANK_EN
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BRIGHT_W     = 3,
    parameter int GUARD_CYCLES = 2
) (
    input logic         clk,
    input logic         reset,
    seg_scan_mux_if.slave bus
);
    localparam int PW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int unsigned STEP = SLOT_CYCLES >> BRIGHT_W;

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stg_digits, act_digits;
    logic [NUM_DIGITS-1:0]   stg_dp, act_dp, stg_blank, act_blank;
    logic                    pending;

    logic                    wrap, boundary, lit;
    logic [PW:0]             win;
    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [3:0]              cur_digit;
    logic                    lead;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign wrap     = (pcnt == PW'(SLOT_CYCLES - 1));
    assign boundary = wrap && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= wrap ? '0 : pcnt + 1'b1;
            if (wrap)
                idx <= boundary ? '0 : idx + 1'b1;
        end
    end

    // An update landing on the boundary cycle bypasses staging so it is not delayed a whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_blank  <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pending    <= 1'b0;
        end else if (boundary) begin
            if (bus.update) begin
                act_digits <= bus.digits_in;
                act_dp     <= bus.dp_in;
                act_blank  <= bus.blank_in;
            end else if (pending) begin
                act_digits <= stg_digits;
                act_dp     <= stg_dp;
                act_blank  <= stg_blank;
            end
            pending <= 1'b0;
        end else if (bus.update) begin
            stg_digits <= bus.digits_in;
            stg_dp     <= bus.dp_in;
            stg_blank  <= bus.blank_in;
            pending    <= 1'b1;
        end
    end

    always_comb begin
        blank_eff = act_blank;
        lead      = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead = lead && (act_digits[4*i +: 4] == 4'h0) && !act_dp[i];
            if (lead)
                blank_eff[i] = 1'b1;
        end
`endif
        cur_digit = act_digits[4*int'(idx) +: 4];
        win       = (PW+1)'((32'(bus.brightness) + 32'd1) * STEP);
        lit       = ({1'b0, pcnt} >= (PW+1)'(GUARD_CYCLES)) && ({1'b0, pcnt} < win)
                    && !blank_eff[idx];
    end

    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [NUM_DIGITS-1:0] ans_r;
    logic                  fs_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
            ans_r <= '1;
            fs_r  <= 1'b0;
        end else begin
            seg_r <= lit ? decode(cur_digit) : 7'h7F;
            dp_r  <= !(lit && act_dp[idx]);
            ans_r <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            fs_r  <= (pcnt == '0) && (idx == '0);
        end
    end

    assign bus.seg         = seg_r;
    assign bus.dp          = dp_r;
    assign bus.ans         = ans_r;
    assign bus.frame_start = fs_r;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux (4 digits, 16-cycle slots)
module tb_seg_scan_mux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg_scan_mux_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS(4), .SLOT_CYCLES(16), .BRIGHT_W(2), .GUARD_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (bus.frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_start_wait", {31'b0, bus.frame_start}, 32'd1);
    endtask

    task automatic apply_update(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] blk);
        bus.digits_in = d;
        bus.dp_in     = dpm;
        bus.blank_in  = blk;
        bus.update    = 1'b1;
        @(negedge clk);
        bus.update    = 1'b0;
        wait_frame_start();
    endtask

    // Starts on a frame_start sample; output cycle j shows slot cycle j%16 of digit j/16.
    task automatic scan_frame(input logic [27:0] segs, input int w, input logic [3:0] blk,
                              input logic [3:0] dpm, input int upd_at, input logic [15:0] upd_d);
        for (int j = 0; j < 64; j++) begin
            int  pc = j % 16;
            int  d  = j / 16;
            logic on;
            bus.update = 1'b0;
            on = (pc >= 2) && (pc < w) && !blk[d];
            check_eq($sformatf("ans_j%0d", j), {28'b0, bus.ans}, on ? {28'b0, ~(4'b0001 << d)} : 32'hF);
            check_eq($sformatf("seg_j%0d", j), {25'b0, bus.seg}, on ? {25'b0, segs[7*d +: 7]} : 32'h7F);
            check_eq($sformatf("dp_j%0d", j), {31'b0, bus.dp}, (on && dpm[d]) ? 32'd0 : 32'd1);
            check_eq($sformatf("fs_j%0d", j), {31'b0, bus.frame_start}, (j == 0) ? 32'd1 : 32'd0);
            if (j == upd_at) begin
                bus.digits_in = upd_d;
                bus.update    = 1'b1;
            end
            @(negedge clk);
        end
        bus.update = 1'b0;
    endtask

    initial begin
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.blank_in   = '0;
        bus.brightness = 2'd3;
        bus.update     = 1'b0;

        // 1: reset state and first frame_start
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_ans", {28'b0, bus.ans}, 32'hF);
            check_eq("rst_seg", {25'b0, bus.seg}, 32'h7F);
            check_eq("rst_dp", {31'b0, bus.dp}, 32'd1);
            check_eq("rst_fs", {31'b0, bus.frame_start}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check_eq("first_fs", {31'b0, bus.frame_start}, 32'd1);

        // 2: 1234 at full brightness
        apply_update(16'h1234, 4'b0000, 4'b0000);
        scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 16, 4'b0000, 4'b0000, -1, 16'h0);

        // 3: dimmest brightness
        bus.brightness = 2'd0;
        scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4, 4'b0000, 4'b0000, -1, 16'h0);

        // 4: mid-frame update is deferred to the next frame
        bus.brightness = 2'd3;
        scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 16, 4'b0000, 4'b0000, 20, 16'h5678);
        // update on the boundary cycle lands straight in the next frame
        scan_frame({7'h12, 7'h02, 7'h78, 7'h00}, 16, 4'b0000, 4'b0000, 62, 16'h1234);
        scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 16, 4'b0000, 4'b0000, -1, 16'h0);

        // 5: blanking and decimal point, at brightness 2
        bus.brightness = 2'd2;
        apply_update(16'h1234, 4'b0001, 4'b1000);
        scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 12, 4'b1000, 4'b0001, -1, 16'h0);

`ifdef LEADING_ZERO_BLANK_EN
        // 6: leading zero suppression
        bus.brightness = 2'd3;
        apply_update(16'h0040, 4'b0000, 4'b0000);
        scan_frame({7'h40, 7'h40, 7'h19, 7'h40}, 16, 4'b1100, 4'b0000, -1, 16'h0);
        apply_update(16'h0000, 4'b0000, 4'b0000);
        scan_frame({7'h40, 7'h40, 7'h40, 7'h40}, 16, 4'b1110, 4'b0000, -1, 16'h0);
`endif

        // reset mid-frame blanks immediately and restarts from digit 0
        bus.brightness = 2'd3;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_ans", {28'b0, bus.ans}, 32'hF);
        check_eq("midrst_seg", {25'b0, bus.seg}, 32'h7F);
        check_eq("midrst_fs", {31'b0, bus.frame_start}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        scan_frame({7'h40, 7'h40, 7'h40, 7'h40}, 16, 4'b0000, 4'b0000, -1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
